// File: rtl/uart_rx_mv.sv
// uart_rx_mv: UART receiver with runtime framing and 3-sample majority voting.
//
// Each bit is oversampled N times. Three samples around mid-bit are voted
// 2-of-3, and the frame acts on that decision. A start bit that votes high is
// treated as a glitch and dropped. Finished words land in a one-entry holding
// register that the consumer drains with a valid/ready handshake. A frame that
// finishes while the register is still full is dropped and flagged with a
// one-cycle overrun pulse.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active low
//   RX_IN          serial line, idle high, asynchronous to clk
//   cfg_par_en     frame carries a parity bit
//   cfg_par_odd    1 = odd parity, 0 = even parity
//   cfg_two_stop   two stop bits are checked
//   DATA_READY     consumer accepts the held word
//   P_DATA_OUT     received word
//   DATA_VALID     held word and its flags are valid
//   parity_error   parity mismatch for the held word
//   stop_error     a stop bit sampled low for the held word
//   overrun_error  1-cycle pulse: frame completed while the register was full
//   busy           FSM is not idle
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a low level on the synchronised line
// S_START  | start bit; a high vote rejects it as a glitch
// S_DATA   | data bits, LSB first, bc selects the bit
// S_PARITY | optional parity bit
// S_STOP1  | first stop bit; frame ends at mid-bit if only one stop bit
// S_STOP2  | second stop bit; frame ends at mid-bit
module uart_rx_mv #(
  parameter int DATA_WIDTH  = 8,
  parameter int N           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_odd,
  input  logic                  cfg_two_stop,
  input  logic                  DATA_READY,
  output logic [DATA_WIDTH-1:0] P_DATA_OUT,
  output logic                  DATA_VALID,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  overrun_error,
  output logic                  busy
);

  localparam int SC_W = $clog2(N);
  localparam int BC_W = $clog2(DATA_WIDTH);

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(N - 1);
  localparam logic [SC_W-1:0] SC_V0   = SC_W'(N / 2 - 1);
  localparam logic [SC_W-1:0] SC_V1   = SC_W'(N / 2);
  localparam logic [SC_W-1:0] SC_DEC  = SC_W'(N / 2 + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [SC_W-1:0]        sc;
  logic [BC_W-1:0]        bc;
  logic                   samp_a, samp_b;
  logic                   vote;
  logic                   decide;
  logic                   sc_last;
  logic [DATA_WIDTH-1:0]  data_sh;
  logic                   par_en_q, par_odd_q, two_stop_q;
  logic                   perr_q, serr_q;
  logic                   serr_fin;
  logic                   frame_done;
  logic                   start_frame;

  // Synchroniser resets to the idle line level so release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign decide  = (sc == SC_DEC);
  assign sc_last = (sc == SC_LAST);
  // Third vote sample is the live line on the decision cycle.
  assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign busy    = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_done  = 1'b0;
    start_frame = 1'b0;
    serr_fin    = ~vote;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d     = S_START;
          start_frame = 1'b1;
        end
      end
      S_START: begin
        if (decide && vote)  state_d = S_IDLE;
        else if (sc_last)    state_d = S_DATA;
      end
      S_DATA: begin
        if (sc_last && (bc == BC_LAST)) state_d = par_en_q ? S_PARITY : S_STOP1;
      end
      S_PARITY: begin
        if (sc_last) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (two_stop_q) begin
          if (sc_last) state_d = S_STOP2;
        end else if (decide) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_STOP2: begin
        serr_fin = serr_q | ~vote;
        if (decide) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame datapath: counters, vote samples, shift register, error accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc         <= '0;
      bc         <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      data_sh    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      if ((state_d != state_q) || sc_last) sc <= '0;
      else if (state_q != S_IDLE)          sc <= sc + 1'b1;

      if (sc == SC_V0) samp_a <= rx_s;
      if (sc == SC_V1) samp_b <= rx_s;

      if (start_frame) begin
        par_en_q   <= cfg_par_en;
        par_odd_q  <= cfg_par_odd;
        two_stop_q <= cfg_two_stop;
        perr_q     <= 1'b0;
        serr_q     <= 1'b0;
      end

      if (state_q == S_START && state_d == S_DATA) bc <= '0;
      else if (state_q == S_DATA && sc_last)       bc <= bc + 1'b1;

      if (decide) begin
        case (state_q)
          S_DATA:   data_sh[bc] <= vote;
          S_PARITY: perr_q      <= ((^data_sh) ^ vote) != par_odd_q;
          S_STOP1:  serr_q      <= ~vote;
          default:  ;
        endcase
      end
    end
  end

  // Holding register. A transfer in the completion cycle frees the slot for the new word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      P_DATA_OUT    <= '0;
      DATA_VALID    <= 1'b0;
      parity_error  <= 1'b0;
      stop_error    <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      if (frame_done && (!DATA_VALID || DATA_READY)) begin
        P_DATA_OUT   <= data_sh;
        parity_error <= perr_q;
        stop_error   <= serr_fin;
        DATA_VALID   <= 1'b1;
      end else begin
        if (frame_done)                   overrun_error <= 1'b1;
        else if (DATA_VALID && DATA_READY) DATA_VALID   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mv.sv
`timescale 1ns/1ps
module tb_uart_rx_mv;

  localparam int DW1  = 8;
  localparam int N1   = 16;
  localparam int DW2  = 5;
  localparam int N2   = 8;
  localparam int NONE = -10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx1 = 1'b1, rx2 = 1'b1;
  logic par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0;
  logic rdy1 = 1'b1, rdy2 = 1'b1;

  logic [DW1-1:0] dout1;
  logic           dv1, pe1, se1, ov1, bz1;
  logic [DW2-1:0] dout2;
  logic           dv2, pe2, se2, ov2, bz2;

  int total = 0;
  int bad   = 0;
  int ovr1  = 0;
  int dvc1  = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        pe;
    logic        se;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  uart_rx_mv #(.DATA_WIDTH(DW1), .N(N1), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .RX_IN(rx1),
    .cfg_par_en(par_en), .cfg_par_odd(par_odd), .cfg_two_stop(two_stop),
    .DATA_READY(rdy1), .P_DATA_OUT(dout1), .DATA_VALID(dv1),
    .parity_error(pe1), .stop_error(se1), .overrun_error(ov1), .busy(bz1)
  );

  uart_rx_mv #(.DATA_WIDTH(DW2), .N(N2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .RX_IN(rx2),
    .cfg_par_en(par_en), .cfg_par_odd(par_odd), .cfg_two_stop(two_stop),
    .DATA_READY(rdy2), .P_DATA_OUT(dout2), .DATA_VALID(dv2),
    .parity_error(pe2), .stop_error(se2), .overrun_error(ov2), .busy(bz2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic score(input int sel, input logic [15:0] d, input logic pe, input logic se);
    exp_t e;
    int   sz;
    sz = (sel == 1) ? q1.size() : q2.size();
    total++;
    assert (sz > 0) else begin
      bad++;
      $error("FAIL dut%0d_unexpected_word observed=%0h expected=none", sel, d);
    end
    if (sz > 0) begin
      if (sel == 1) e = q1.pop_front();
      else          e = q2.pop_front();
      check($sformatf("dut%0d_data", sel), 32'(d), 32'(e.d));
      check($sformatf("dut%0d_parity_error", sel), 32'(pe), 32'(e.pe));
      check($sformatf("dut%0d_stop_error", sel), 32'(se), 32'(e.se));
    end
  endtask

  // Scoreboard side: a word is consumed on each valid & ready cycle.
  always @(negedge clk) begin
    if (rst && ov1) ovr1++;
    if (rst && dv1) dvc1++;
    if (rst && dv1 && rdy1) score(1, 16'(dout1), pe1, se1);
  end

  always @(negedge clk) begin
    if (rst && dv2 && rdy2) score(2, 16'(dout2), pe2, se2);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_rx(input int sel, input logic v);
    if (sel == 1) rx1 = v;
    else          rx2 = v;
  endtask

  function automatic logic exp_perr(input logic [15:0] d, input logic pbit);
    return par_en ? (((^d) ^ pbit) != par_odd) : 1'b0;
  endfunction

  task automatic expect_word(input int sel, input logic [15:0] d, input logic pbit, input logic se);
    exp_t e;
    e.d  = d;
    e.pe = exp_perr(d, pbit);
    e.se = se;
    if (sel == 1) q1.push_back(e);
    else          q2.push_back(e);
  endtask

  // Serial frame driver. gbit/goff invert one oversample of data bit gbit;
  // abort_bit returns at the start of that data bit.
  task automatic send(input int sel, input logic [15:0] d, input logic pbit,
                      input logic s1, input logic s2,
                      input int gbit, input int goff, input int abort_bit);
    int          dw, n, nb;
    logic [23:0] bits;
    dw   = (sel == 1) ? DW1 : DW2;
    n    = (sel == 1) ? N1 : N2;
    bits = '0;
    nb   = 1;
    for (int i = 0; i < dw; i++) begin
      bits[nb] = d[i];
      nb++;
    end
    if (par_en) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = s1;
    nb++;
    if (two_stop) begin
      bits[nb] = s2;
      nb++;
    end
    for (int b = 0; b < nb; b++) begin
      if (b == abort_bit + 1) return;
      for (int c = 0; c < n; c++) begin
        drive_rx(sel, (b == gbit + 1 && c == goff) ? ~bits[b] : bits[b]);
        tick(1);
      end
    end
    drive_rx(sel, 1'b1);
  endtask

  task automatic drain(input int sel, input int max);
    int k;
    k = 0;
    while (((sel == 1) ? q1.size() : q2.size()) != 0 && k < max) begin
      tick(1);
      k++;
    end
    check($sformatf("dut%0d_drain", sel), (sel == 1) ? q1.size() : q2.size(), 0);
  endtask

  task automatic reset_case(input int sel, input logic [15:0] hold_d, input logic hold_pbit,
                            input logic [15:0] new_d);
    logic [15:0] od;
    logic        odv, ope, ose, oov, obz;
    if (sel == 1) rdy1 = 1'b0;
    else          rdy2 = 1'b0;
    send(sel, hold_d, hold_pbit, 1'b1, 1'b1, NONE, 0, NONE);
    tick(3);
    odv = (sel == 1) ? dv1 : dv2;
    check($sformatf("dut%0d_held_before_reset", sel), 32'(odv), 1);
    send(sel, 16'h000F, 1'b0, 1'b1, 1'b1, NONE, 0, 4);
    obz = (sel == 1) ? bz1 : bz2;
    check($sformatf("dut%0d_busy_mid_frame", sel), 32'(obz), 1);
    rst = 1'b0;
    #1;
    od  = (sel == 1) ? 16'(dout1) : 16'(dout2);
    odv = (sel == 1) ? dv1 : dv2;
    ope = (sel == 1) ? pe1 : pe2;
    ose = (sel == 1) ? se1 : se2;
    oov = (sel == 1) ? ov1 : ov2;
    obz = (sel == 1) ? bz1 : bz2;
    check($sformatf("dut%0d_rst_data", sel), 32'(od), 0);
    check($sformatf("dut%0d_rst_valid", sel), 32'(odv), 0);
    check($sformatf("dut%0d_rst_perr", sel), 32'(ope), 0);
    check($sformatf("dut%0d_rst_serr_ovr", sel), 32'({ose, oov}), 0);
    check($sformatf("dut%0d_rst_busy", sel), 32'(obz), 0);
    drive_rx(sel, 1'b1);
    if (sel == 1) rdy1 = 1'b1;
    else          rdy2 = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(4);
    expect_word(sel, new_d, (^new_d) ^ par_odd, 1'b0);
    send(sel, new_d, (^new_d) ^ par_odd, 1'b1, 1'b1, NONE, 0, NONE);
    drain(sel, 4 * N1);
  endtask

  initial begin
    int c0;

    // Reset state
    #3 rst = 1'b0;
    #1;
    check("rst_data", 32'(dout1), 0);
    check("rst_valid_flags", 32'({dv1, pe1, se1, ov1}), 0);
    check("rst_busy", 32'(bz1), 0);
    tick(3);
    rst = 1'b1;
    tick(4);

    // 1: plain frame, no parity, one stop bit
    c0 = dvc1;
    expect_word(1, 16'hA5, 1'b0, 1'b0);
    send(1, 16'hA5, 1'b0, 1'b1, 1'b1, NONE, 0, NONE);
    drain(1, 40);
    tick(2);
    check("t1_one_valid_pulse", dvc1 - c0, 1);
    check("t1_busy_after", 32'(bz1), 0);

    // 2a: short low glitch is rejected as a false start
    c0  = dvc1;
    rx1 = 1'b0;
    tick(3);
    rx1 = 1'b1;
    tick(2);
    check("t2_busy_during_glitch", 32'(bz1), 1);
    for (int k = 0; k < N1 && bz1; k++) tick(1);
    check("t2_busy_returns_idle", 32'(bz1), 0);
    tick(N1);
    check("t2_no_word", dvc1 - c0, 0);

    // 2b: one inverted vote sample in data bit 3 is outvoted
    expect_word(1, 16'h00, 1'b0, 1'b0);
    send(1, 16'h00, 1'b0, 1'b1, 1'b1, 3, N1 / 2 + 1, NONE);
    drain(1, 40);
    tick(4);

    // 3: parity
    par_en  = 1'b1;
    par_odd = 1'b1;
    expect_word(1, 16'h01, 1'b1, 1'b0);
    send(1, 16'h01, 1'b1, 1'b1, 1'b1, NONE, 0, NONE);
    drain(1, 40);
    tick(4);
    expect_word(1, 16'h01, 1'b0, 1'b0);
    send(1, 16'h01, 1'b0, 1'b1, 1'b1, NONE, 0, NONE);
    drain(1, 40);
    tick(4);
    par_odd = 1'b0;
    expect_word(1, 16'hA5, 1'b1, 1'b0);
    send(1, 16'hA5, 1'b1, 1'b1, 1'b1, NONE, 0, NONE);
    drain(1, 40);
    tick(4);
    par_en = 1'b0;

    // 4: two stop bits
    two_stop = 1'b1;
    expect_word(1, 16'h3C, 1'b0, 1'b1);
    send(1, 16'h3C, 1'b0, 1'b1, 1'b0, NONE, 0, NONE);
    drain(1, 40);
    tick(4);
    expect_word(1, 16'h3C, 1'b0, 1'b0);
    send(1, 16'h3C, 1'b0, 1'b1, 1'b1, NONE, 0, NONE);
    drain(1, 40);
    tick(4);
    expect_word(1, 16'hC3, 1'b0, 1'b1);
    send(1, 16'hC3, 1'b0, 1'b0, 1'b1, NONE, 0, NONE);
    drain(1, 40);
    tick(4);
    two_stop = 1'b0;

    // 5: overrun with the consumer stalled
    rdy1 = 1'b0;
    ovr1 = 0;
    expect_word(1, 16'h11, 1'b0, 1'b0);
    send(1, 16'h11, 1'b0, 1'b1, 1'b1, NONE, 0, NONE);
    send(1, 16'h22, 1'b0, 1'b1, 1'b1, NONE, 0, NONE);
    tick(4);
    check("t5_overrun_one_cycle", ovr1, 1);
    check("t5_held_valid", 32'(dv1), 1);
    check("t5_held_data", 32'(dout1), 32'h11);
    rdy1 = 1'b1;
    drain(1, 10);
    tick(1);
    check("t5_valid_dropped", 32'(dv1), 0);
    tick(4);

    // 6: asynchronous reset mid-frame, both configurations
    reset_case(1, 16'h33, 1'b0, 16'h5A);
    tick(4);
    par_en  = 1'b1;
    par_odd = 1'b0;
    reset_case(2, 16'h13, 1'b0, 16'h1A);
    par_en = 1'b0;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
